// File: rtl/zx_kbd_matrix_if.sv
// PS/2 byte stream in, ZX port FEh read, help toggle and key event out.
interface zx_kbd_matrix_if;
  logic        ps2_data_clk;
  logic [7:0]  ps2_data;
  logic [15:0] A;
  logic [7:0]  D;
  logic        f1_screen;
  logic        key_event;

  modport master (
    output ps2_data_clk, ps2_data, A,
    input  D, f1_screen, key_event
  );

  modport slave (
    input  ps2_data_clk, ps2_data, A,
    output D, f1_screen, key_event
  );
endinterface

// File: rtl/zx_kbd_matrix.sv
// PS/2 set-2 scancodes to an 8x5 ZX key matrix; D is combinational from A, key_event 1 cycle late.
// Define ZX_EXT_KEYS_EN to map Backspace and the cursor keys as CAPS-shifted composites.
module zx_kbd_matrix #(
  parameter int         SKIP_E1 = 7,
  parameter logic [2:0] D_HIGH  = 3'b111
) (
  input logic             CLOCK_50,
  input logic             RESET_N,
  zx_kbd_matrix_if.slave  bus
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_BRK  = 3'd1;
  localparam logic [2:0] ST_EXT  = 3'd2;
  localparam logic [2:0] ST_EBRK = 3'd3;
  localparam logic [2:0] ST_SKIP = 3'd4;

  localparam logic [7:0] SKIP_LOAD = 8'(SKIP_E1);

  // One held flag per physical key; indices 0..39 are row*5+bit, the rest are aliases.
`ifdef ZX_EXT_KEYS_EN
  localparam int NK = 48;
`else
  localparam int NK = 43;
`endif

  logic [2:0]    state, next_state;
  logic [7:0]    skip_cnt, next_cnt;
  logic [NK-1:0] held;
  logic          f1_held;
  logic          f1_screen_q;
  logic          key_event_q;

  logic          key_do, key_make, key_ext;
  logic [6:0]    map;
  logic          hit, is_f1;
  logic [7:0]    b;

  logic [7:0][4:0] rows;
  logic [4:0]      sel;
  logic            unused_a;

  function automatic logic [6:0] map_code(input logic ext, input logic [7:0] code);
    logic [6:0] m;
    m = '0;
    if (!ext) begin
      case (code)
        8'h12: m = {1'b1, 6'd0};
        8'h1A: m = {1'b1, 6'd1};
        8'h22: m = {1'b1, 6'd2};
        8'h21: m = {1'b1, 6'd3};
        8'h2A: m = {1'b1, 6'd4};
        8'h1C: m = {1'b1, 6'd5};
        8'h1B: m = {1'b1, 6'd6};
        8'h23: m = {1'b1, 6'd7};
        8'h2B: m = {1'b1, 6'd8};
        8'h34: m = {1'b1, 6'd9};
        8'h15: m = {1'b1, 6'd10};
        8'h1D: m = {1'b1, 6'd11};
        8'h24: m = {1'b1, 6'd12};
        8'h2D: m = {1'b1, 6'd13};
        8'h2C: m = {1'b1, 6'd14};
        8'h16: m = {1'b1, 6'd15};
        8'h1E: m = {1'b1, 6'd16};
        8'h26: m = {1'b1, 6'd17};
        8'h25: m = {1'b1, 6'd18};
        8'h2E: m = {1'b1, 6'd19};
        8'h45: m = {1'b1, 6'd20};
        8'h46: m = {1'b1, 6'd21};
        8'h3E: m = {1'b1, 6'd22};
        8'h3D: m = {1'b1, 6'd23};
        8'h36: m = {1'b1, 6'd24};
        8'h4D: m = {1'b1, 6'd25};
        8'h44: m = {1'b1, 6'd26};
        8'h43: m = {1'b1, 6'd27};
        8'h3C: m = {1'b1, 6'd28};
        8'h35: m = {1'b1, 6'd29};
        8'h5A: m = {1'b1, 6'd30};
        8'h4B: m = {1'b1, 6'd31};
        8'h42: m = {1'b1, 6'd32};
        8'h3B: m = {1'b1, 6'd33};
        8'h33: m = {1'b1, 6'd34};
        8'h29: m = {1'b1, 6'd35};
        8'h59: m = {1'b1, 6'd36};
        8'h3A: m = {1'b1, 6'd37};
        8'h31: m = {1'b1, 6'd38};
        8'h32: m = {1'b1, 6'd39};
        8'h14: m = {1'b1, 6'd41};
`ifdef ZX_EXT_KEYS_EN
        8'h66: m = {1'b1, 6'd43};
`endif
        default: m = '0;
      endcase
    end else begin
      case (code)
        8'h5A: m = {1'b1, 6'd40};
        8'h14: m = {1'b1, 6'd42};
`ifdef ZX_EXT_KEYS_EN
        8'h6B: m = {1'b1, 6'd44};
        8'h72: m = {1'b1, 6'd45};
        8'h75: m = {1'b1, 6'd46};
        8'h74: m = {1'b1, 6'd47};
`endif
        default: m = '0;
      endcase
    end
    return m;
  endfunction

  assign b = bus.ps2_data;

  always_comb begin
    next_state = state;
    next_cnt   = skip_cnt;
    key_do     = 1'b0;
    key_make   = 1'b0;
    key_ext    = 1'b0;
    if (bus.ps2_data_clk) begin
      case (state)
        ST_IDLE: begin
          case (b)
            8'hF0: next_state = ST_BRK;
            8'hE0: next_state = ST_EXT;
            8'hE1: begin
              next_cnt   = SKIP_LOAD;
              next_state = (SKIP_LOAD == 8'd0) ? ST_IDLE : ST_SKIP;
            end
            8'hAA, 8'hFA, 8'hEE, 8'h00, 8'hFF: next_state = ST_IDLE;
            default: begin
              key_do   = 1'b1;
              key_make = 1'b1;
            end
          endcase
        end
        ST_BRK: begin
          key_do     = 1'b1;
          next_state = ST_IDLE;
        end
        ST_EXT: begin
          if (b == 8'hF0) begin
            next_state = ST_EBRK;
          end else begin
            key_do     = 1'b1;
            key_make   = 1'b1;
            key_ext    = 1'b1;
            next_state = ST_IDLE;
          end
        end
        ST_EBRK: begin
          key_do     = 1'b1;
          key_ext    = 1'b1;
          next_state = ST_IDLE;
        end
        ST_SKIP: begin
          next_cnt = skip_cnt - 8'd1;
          if (skip_cnt <= 8'd1) next_state = ST_IDLE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  assign map   = map_code(key_ext, b);
  assign hit   = key_do & map[6];
  assign is_f1 = key_do & ~key_ext & (b == 8'h05);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      skip_cnt    <= 8'd0;
      held        <= '0;
      f1_held     <= 1'b0;
      f1_screen_q <= 1'b0;
      key_event_q <= 1'b0;
    end else begin
      state       <= next_state;
      skip_cnt    <= next_cnt;
      key_event_q <= hit | is_f1;
      if (hit) held[map[5:0]] <= key_make;
      // Typematic repeats arrive as makes with f1_held still set and must not toggle.
      if (is_f1) begin
        if (key_make) begin
          if (!f1_held) begin
            f1_screen_q <= ~f1_screen_q;
            f1_held     <= 1'b1;
          end
        end else begin
          f1_held <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 8; r++) rows[r] = held[r*5 +: 5];
    rows[6][0] = held[30] | held[40];
    rows[7][1] = held[36] | held[41] | held[42];
`ifdef ZX_EXT_KEYS_EN
    rows[0][0] = held[0] | (|held[47:43]);
    rows[4][0] = held[20] | held[43];
    rows[3][4] = held[19] | held[44];
    rows[4][4] = held[24] | held[45];
    rows[4][3] = held[23] | held[46];
    rows[4][2] = held[22] | held[47];
`endif
  end

  always_comb begin
    sel = '0;
    for (int r = 0; r < 8; r++) begin
      if (!bus.A[8+r]) sel = sel | rows[r];
    end
  end

  assign bus.D         = {D_HIGH, ~sel};
  assign bus.f1_screen = f1_screen_q;
  assign bus.key_event = key_event_q;
  assign unused_a      = ^bus.A[7:0];

endmodule

// File: tb/tb_zx_kbd_matrix.sv
// Directed stimulus for zx_kbd_matrix with a queue-based scoreboard of expected reads and events.
module tb_zx_kbd_matrix;
  logic CLOCK_50;
  logic RESET_N;
  int   checks;
  int   failures;

  logic [7:0] dq[$];
  logic       evq[$];

  zx_kbd_matrix_if bus();

  zx_kbd_matrix dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .bus      (bus)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Strobe one byte; key_event is checked on the following half cycle unless exp_evt < 0.
  task automatic send(input logic [7:0] bt, input int exp_evt);
    @(negedge CLOCK_50);
    bus.ps2_data_clk = 1'b1;
    bus.ps2_data     = bt;
    if (exp_evt >= 0) evq.push_back(exp_evt[0]);
    @(negedge CLOCK_50);
    bus.ps2_data_clk = 1'b0;
    if (exp_evt >= 0) chk("key_event", {7'b0, bus.key_event}, {7'b0, evq.pop_front()});
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] e);
    bus.A = a;
    dq.push_back(e);
    #1;
    chk(tag, bus.D, dq.pop_front());
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RESET_N  = 1'b0;
    bus.ps2_data_clk = 1'b0;
    bus.ps2_data     = 8'h00;
    bus.A            = 16'hFFFF;

    // Reset state; a strobe under reset must be ignored.
    repeat (2) @(negedge CLOCK_50);
    rd("rst_d", 16'hFEFE, 8'hFF);
    chk("rst_f1", {7'b0, bus.f1_screen}, 8'h00);
    send(8'h1C, 0);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
    rd("rst_strobe_ignored", 16'hFDFE, 8'hFF);
    rd("all_rows_idle", 16'h00FE, 8'hFF);

    // A make then break.
    send(8'h1C, 1);
    rd("a_make", 16'hFDFE, 8'hFE);
    rd("a_other_row", 16'hFEFE, 8'hFF);
    send(8'hF0, 0);
    send(8'h1C, 1);
    rd("a_break", 16'hFDFE, 8'hFF);

    // Shift aliases: LShift is CAPS, RShift is SymShift.
    send(8'h12, 1);
    send(8'h59, 1);
    rd("two_rows", 16'h7EFE, 8'hFC);
    send(8'hF0, 0);
    send(8'h12, 1);
    rd("symshift_held", 16'h7FFE, 8'hFD);
    rd("caps_released", 16'hFEFE, 8'hFF);
    send(8'hF0, 0);
    send(8'h59, 1);
    rd("symshift_released", 16'h7FFE, 8'hFF);

    // SymShift via LCtrl and E0 14: releasing one keeps the bit.
    send(8'h14, 1);
    send(8'hE0, 0);
    send(8'h14, 1);
    send(8'hF0, 0);
    send(8'h14, 1);
    rd("ctrl_alias_held", 16'h7FFE, 8'hFD);
    send(8'hE0, 0);
    send(8'hF0, 0);
    send(8'h14, 1);
    rd("ctrl_alias_rel", 16'h7FFE, 8'hFF);

    // Enter alias.
    send(8'h5A, 1);
    send(8'hE0, 0);
    send(8'h5A, 1);
    send(8'hF0, 0);
    send(8'h5A, 1);
    rd("enter_alias_held", 16'hBFFE, 8'hFE);
    send(8'hE0, 0);
    send(8'hF0, 0);
    send(8'h5A, 1);
    rd("enter_alias_rel", 16'hBFFE, 8'hFF);

    // F1 toggle with typematic repeat.
    send(8'h05, -1);
    chk("f1_first", {7'b0, bus.f1_screen}, 8'h01);
    send(8'h05, -1);
    send(8'h05, -1);
    chk("f1_repeat", {7'b0, bus.f1_screen}, 8'h01);
    send(8'hF0, 0);
    send(8'h05, -1);
    chk("f1_break", {7'b0, bus.f1_screen}, 8'h01);
    send(8'h05, -1);
    chk("f1_second", {7'b0, bus.f1_screen}, 8'h00);
    send(8'hF0, 0);
    send(8'h05, -1);

    // Ignored control bytes and an unmapped code.
    send(8'hAA, 0);
    send(8'hFA, 0);
    send(8'h0E, 0);

    // Pause sequence: E1 plus seven bytes discarded.
    send(8'hE1, 0);
    send(8'h14, 0);
    send(8'h77, 0);
    send(8'hE1, 0);
    send(8'hF0, 0);
    send(8'h14, 0);
    send(8'hF0, 0);
    send(8'h77, 0);
    rd("pause_symshift_clear", 16'h7FFE, 8'hFF);
    send(8'h1C, 1);
    rd("after_pause", 16'hFDFE, 8'hFE);
    send(8'hF0, 0);
    send(8'h1C, 1);

    // Composite keys.
    send(8'h12, 1);
    send(8'hE0, 0);
`ifdef ZX_EXT_KEYS_EN
    send(8'h6B, 1);
`else
    send(8'h6B, 0);
`endif
    send(8'hF0, 0);
    send(8'h12, 1);
`ifdef ZX_EXT_KEYS_EN
    rd("comp_caps", 16'hFEFE, 8'hFE);
    rd("comp_5", 16'hF7FE, 8'hEF);
    send(8'hE0, 0);
    send(8'hF0, 0);
    send(8'h6B, 1);
    rd("comp_caps_rel", 16'hFEFE, 8'hFF);
    rd("comp_5_rel", 16'hF7FE, 8'hFF);
`else
    rd("no_comp_5", 16'hF7FE, 8'hFF);
    rd("no_comp_caps", 16'hFEFE, 8'hFF);
    send(8'h66, 0);
    rd("no_backspace", 16'hEFFE, 8'hFF);
`endif

    // Reset between F0 and the code byte returns to IDLE.
    send(8'h1C, 1);
    send(8'hF0, 0);
    @(negedge CLOCK_50);
    RESET_N = 1'b0;
    @(negedge CLOCK_50);
    rd("mid_rst_clear", 16'hFDFE, 8'hFF);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
    send(8'h1C, 1);
    rd("mid_rst_idle", 16'hFDFE, 8'hFE);
    send(8'hF0, 0);
    send(8'h1C, 1);

    // Strobe in the same cycle as an A change: D shows the old matrix first.
    bus.A = 16'hFFFF;
    @(negedge CLOCK_50);
    bus.A            = 16'hFDFE;
    bus.ps2_data_clk = 1'b1;
    bus.ps2_data     = 8'h1C;
    dq.push_back(8'hFF);
    #1;
    chk("same_cycle_pre", bus.D, dq.pop_front());
    @(negedge CLOCK_50);
    bus.ps2_data_clk = 1'b0;
    dq.push_back(8'hFE);
    chk("same_cycle_post", bus.D, dq.pop_front());

    repeat (2) @(negedge CLOCK_50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
